usc_rv_ibuf: RTL and testbench



---
 rtl/usc_rv_pkg.sv | 33 +++
 rtl/usc_rv_ibuf_if.sv | 42 ++++
 rtl/usc_rv_ibuf_rdmux.sv | 26 ++
 rtl/usc_rv_ibuf.sv | 149 ++++++++++++++
 tb/tb_usc_rv_ibuf.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usc_rv_pkg.sv
// Shared types for the usc_rv instruction buffer.
// Optional same-cycle bypass: USC_RV_IBUF_BYPASS_EN.
package usc_rv_pkg;

  localparam int USC_RV_FETCH_INFO_W = 3;

  localparam logic [31:0] USC_RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic        fault_page;
    logic        fault_fetch;
  } usc_rv_ibuf_entry_t;

  // Faulted fetches carry no usable word, so it is zeroed at capture.
  function automatic usc_rv_ibuf_entry_t usc_rv_mk_entry(
    input logic [31:0] pc,
    input logic [31:0] word,
    input logic        pred,
    input logic [1:0]  fault
  );
    usc_rv_ibuf_entry_t e;
    e.pc          = pc;
    e.instr       = (|fault) ? 32'h0 : word;
    e.pred        = pred;
    e.fault_page  = fault[1];
    e.fault_fetch = fault[0];
    return e;
  endfunction

endpackage

// File: rtl/usc_rv_ibuf_if.sv
// Fetch-group and decode-lane bundle of the instruction buffer.
// master = fetch/decode side, slave = buffer.
interface usc_rv_ibuf_if #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int CONS_W  = $clog2(ISSUE_W + 1)
);
  logic                   flush_i;
  logic [FETCH_W-1:0]     in_vld_i;
  logic                   in_rdy_o;
  logic [31:0]            in_pc_i;
  logic [FETCH_W*32-1:0]  in_data_i;
  logic [FETCH_W-1:0]     in_pred_i;
  logic [1:0]             in_fault_i;
  logic [ISSUE_W-1:0]     out_vld_o;
  logic [ISSUE_W*32-1:0]  out_pc_o;
  logic [ISSUE_W*32-1:0]  out_data_o;
  logic [ISSUE_W-1:0]     out_pred_o;
  logic [ISSUE_W*2-1:0]   out_fault_o;
  logic [CONS_W-1:0]      out_consume_i;
  logic [CNT_W-1:0]       count_o;

  modport master (
    output flush_i, in_vld_i, in_pc_i,
    output in_data_i, in_pred_i, in_fault_i,
    output out_consume_i,
    input  in_rdy_o, out_vld_o, out_pc_o,
    input  out_data_o, out_pred_o,
    input  out_fault_o, count_o
  );

  modport slave (
    input  flush_i, in_vld_i, in_pc_i,
    input  in_data_i, in_pred_i, in_fault_i,
    input  out_consume_i,
    output in_rdy_o, out_vld_o, out_pc_o,
    output out_data_o, out_pred_o,
    output out_fault_o, count_o
  );
endinterface

// File: rtl/usc_rv_ibuf_rdmux.sv
// Rotates the oldest ISSUE_W queue entries onto decode lanes.
// Invalid lanes are filled with a NOP for easier debug.
module usc_rv_ibuf_rdmux
  import usc_rv_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  usc_rv_ibuf_entry_t mem [DEPTH],
  input  logic [PTR_W-1:0]   rd_ptr,
  input  logic [CNT_W-1:0]   count,
  output usc_rv_ibuf_entry_t lane [ISSUE_W],
  output logic [ISSUE_W-1:0] vld
);

  always_comb begin
    for (int j = 0; j < ISSUE_W; j++) begin
      vld[j]  = CNT_W'(j) < count;
      lane[j] = mem[rd_ptr + PTR_W'(j)];
      if (!vld[j]) lane[j].instr = USC_RV_NOP;
    end
  end

endmodule

// File: rtl/usc_rv_ibuf.sv
// Parametrised F2->decode instruction queue with redirect flush.
// Define USC_RV_IBUF_BYPASS_EN for 0-cycle empty-buffer latency.
module usc_rv_ibuf
  import usc_rv_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input logic        clk_i,
  input logic        rstn_i,
  usc_rv_ibuf_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CONS_W = $clog2(ISSUE_W + 1);

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  usc_rv_ibuf_entry_t mem    [DEPTH];
  usc_rv_ibuf_entry_t grp    [FETCH_W];
  usc_rv_ibuf_entry_t lane_q [ISSUE_W];
  usc_rv_ibuf_entry_t lane   [ISSUE_W];

  logic [ISSUE_W-1:0] vld_q;
  logic [ISSUE_W-1:0] vld;
  logic [FETCH_W-1:0] run;
  logic               in_rdy;
  logic               push_en;
  logic [CNT_W-1:0]   n_push;
  logic [CONS_W-1:0]  n_stored;
  logic [CONS_W-1:0]  n_vis;
  logic [CONS_W-1:0]  n_cons;
  logic [CONS_W-1:0]  n_skip;

  assign in_rdy  = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
  assign push_en = in_rdy & run[0];

  // Only the contiguous low run of valids forms the group.
  always_comb begin
    logic alive;
    alive  = 1'b1;
    run    = '0;
    n_push = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      alive  = alive & bus.in_vld_i[k];
      run[k] = alive;
      n_push = n_push + CNT_W'(alive);
      grp[k] = usc_rv_mk_entry(
        bus.in_pc_i + 32'(4 * k),
        bus.in_data_i[k*32 +: 32],
        bus.in_pred_i[k],
        bus.in_fault_i);
    end
  end

  usc_rv_ibuf_rdmux #(
    .ISSUE_W (ISSUE_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .PTR_W   (PTR_W)
  ) u_rdmux (
    .mem    (mem),
    .rd_ptr (rd_ptr),
    .count  (count),
    .lane   (lane_q),
    .vld    (vld_q)
  );

  always_comb begin
    lane = lane_q;
    vld  = vld_q;
`ifdef USC_RV_IBUF_BYPASS_EN
    for (int j = 0; j < ISSUE_W; j++) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (push_en && !bus.flush_i && run[k] &&
            !vld_q[j] && (int'(n_stored) + k == j)) begin
          lane[j] = grp[k];
          vld[j]  = 1'b1;
        end
      end
    end
`endif
  end

  // Consume is clamped to what decode can actually see.
  always_comb begin
    n_stored = '0;
    n_vis    = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      n_stored = n_stored + CONS_W'(vld_q[j]);
      n_vis    = n_vis + CONS_W'(vld[j]);
    end
    n_cons = (bus.out_consume_i > n_vis) ? n_vis
                                         : bus.out_consume_i;
    n_skip = (n_cons > n_stored) ? (n_cons - n_stored)
                                 : '0;
  end

  // Slots already retired through the bypass skip storage.
  always_ff @(posedge clk_i) begin
    if (rstn_i && !bus.flush_i && push_en) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (run[k] && (k >= int'(n_skip)))
          mem[wr_ptr + PTR_W'(k)] <= grp[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(n_cons);
      count  <= count + (push_en ? n_push : '0)
                      - CNT_W'(n_cons);
    end
  end

  always_comb begin
    for (int j = 0; j < ISSUE_W; j++) begin
      bus.out_pc_o[j*32 +: 32]   = lane[j].pc;
      bus.out_data_o[j*32 +: 32] = lane[j].instr;
      bus.out_pred_o[j]          = lane[j].pred;
      bus.out_fault_o[j*2 +: 2]  = {lane[j].fault_page,
                                    lane[j].fault_fetch};
    end
  end

  assign bus.out_vld_o = vld;
  assign bus.in_rdy_o  = in_rdy;
  assign bus.count_o   = count;

  always_ff @(posedge clk_i) begin
    if (rstn_i && !bus.flush_i) begin
      assert (bus.out_consume_i <= n_vis)
        else $error("ibuf: consume exceeds valid lanes");
      assert ((bus.in_vld_i & (bus.in_vld_i + 1'b1)) == '0)
        else $error("ibuf: non-contiguous in_vld_i");
    end
  end

endmodule

// File: tb/tb_usc_rv_ibuf.sv
// Self-checking bench for usc_rv_ibuf: vector table, corner
// sequences and a randomized queue-model run.
module tb_usc_rv_ibuf;
  import usc_rv_pkg::*;

  localparam int F = 2;
  localparam int I = 2;
  localparam int D = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  usc_rv_ibuf_if #(.FETCH_W(F), .ISSUE_W(I), .DEPTH(D)) bus ();

  usc_rv_ibuf #(.FETCH_W(F), .ISSUE_W(I), .DEPTH(D)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] vld,
                       input logic [31:0] pc,
                       input logic [63:0] data,
                       input logic [1:0] pred,
                       input logic [1:0] fault,
                       input logic [1:0] cons,
                       input logic fl,
                       input logic rn);
    bus.in_vld_i      = vld;
    bus.in_pc_i       = pc;
    bus.in_data_i     = data;
    bus.in_pred_i     = pred;
    bus.in_fault_i    = fault;
    bus.out_consume_i = cons;
    bus.flush_i       = fl;
    rstn              = rn;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 64'h0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic        rn;
    logic        fl;
    logic [1:0]  vld;
    logic [31:0] pc;
    logic [63:0] data;
    logic [1:0]  fault;
    logic [1:0]  cons;
    logic [3:0]  e_cnt;
    logic [1:0]  e_vld;
    logic        e_rdy;
    logic [31:0] e_pc0;
    logic [31:0] e_dat0;
    logic [1:0]  e_flt0;
  } vec_t;

  vec_t tbl [14];

  // Reference: a plain queue of what decode should see, oldest first.
  usc_rv_ibuf_entry_t q [$];

  function automatic usc_rv_ibuf_entry_t mk(
      input logic [31:0] pc, input logic [31:0] w,
      input logic p, input logic [1:0] f);
    usc_rv_ibuf_entry_t e;
    e.pc          = pc;
    e.instr       = (f != 2'b00) ? 32'h0 : w;
    e.pred        = p;
    e.fault_page  = f[1];
    e.fault_fetch = f[0];
    return e;
  endfunction

  task automatic do_reset();
    drive(2'b00, 32'h0, 64'h0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    idle();
    q.delete();
    #1;
  endtask

  task automatic mcycle(input logic [1:0] vld,
                        input logic [31:0] pc,
                        input logic [63:0] data,
                        input logic [1:0] pred,
                        input logic [1:0] fault,
                        input logic [1:0] cons,
                        input logic fl,
                        input logic rn);
    usc_rv_ibuf_entry_t vis [$];
    usc_rv_ibuf_entry_t g [$];
    usc_rv_ibuf_entry_t e;
    bit rdy;
    drive(vld, pc, data, pred, fault, cons, fl, rn);
    #1;
    rdy = (D - q.size()) >= F;
    for (int k = 0; k < F; k++) begin
      if (!vld[k]) break;
      g.push_back(mk(pc + 32'(4 * k), data[k*32 +: 32],
                     pred[k], fault));
    end
    vis = q;
`ifdef USC_RV_IBUF_BYPASS_EN
    if (rdy && !fl) foreach (g[k]) vis.push_back(g[k]);
`endif
    chk("m_count", 64'(bus.count_o), 64'(q.size()));
    chk("m_rdy", 64'(bus.in_rdy_o), 64'(rdy));
    for (int j = 0; j < I; j++) begin
      chk("m_vld", 64'(bus.out_vld_o[j]), 64'(j < vis.size()));
      if (j < vis.size()) begin
        e = vis[j];
        chk("m_pc", 64'(bus.out_pc_o[j*32 +: 32]), 64'(e.pc));
        chk("m_data", 64'(bus.out_data_o[j*32 +: 32]),
            64'(e.instr));
        chk("m_pred", 64'(bus.out_pred_o[j]), 64'(e.pred));
        chk("m_fault", 64'(bus.out_fault_o[j*2 +: 2]),
            64'({e.fault_page, e.fault_fetch}));
      end
    end
    @(posedge clk);
    if (!rn || fl) q.delete();
    else begin
      if (rdy) foreach (g[k]) q.push_back(g[k]);
      for (int c = 0; c < cons; c++) void'(q.pop_front());
    end
    #1;
  endtask

  initial begin
    logic [31:0] ppc;
    logic [31:0] rpc;
    int qs;
    int maxc;

    tbl[0]  = '{0, 0, 2'b00, 32'h0, 64'h0, 2'b00, 2'd0,
                4'd0, 2'b00, 1, 32'h0, 32'h0, 2'b00};
    tbl[1]  = '{1, 0, 2'b11, 32'h1000,
                64'hAAAA_0002_AAAA_0001, 2'b00, 2'd0,
                4'd2, 2'b11, 1, 32'h1000, 32'hAAAA_0001, 2'b00};
    tbl[2]  = '{1, 0, 2'b11, 32'h1008,
                64'hAAAA_0004_AAAA_0003, 2'b00, 2'd0,
                4'd4, 2'b11, 1, 32'h1000, 32'hAAAA_0001, 2'b00};
    tbl[3]  = '{1, 0, 2'b11, 32'h1010,
                64'hAAAA_0006_AAAA_0005, 2'b00, 2'd0,
                4'd6, 2'b11, 1, 32'h1000, 32'hAAAA_0001, 2'b00};
    tbl[4]  = '{1, 0, 2'b11, 32'h1018,
                64'hAAAA_0008_AAAA_0007, 2'b00, 2'd0,
                4'd8, 2'b11, 0, 32'h1000, 32'hAAAA_0001, 2'b00};
    tbl[5]  = '{1, 0, 2'b11, 32'h1020,
                64'hAAAA_000A_AAAA_0009, 2'b00, 2'd0,
                4'd8, 2'b11, 0, 32'h1000, 32'hAAAA_0001, 2'b00};
    tbl[6]  = '{1, 0, 2'b00, 32'h0, 64'h0, 2'b00, 2'd2,
                4'd6, 2'b11, 1, 32'h1008, 32'hAAAA_0003, 2'b00};
    tbl[7]  = '{1, 0, 2'b00, 32'h0, 64'h0, 2'b00, 2'd1,
                4'd5, 2'b11, 1, 32'h100C, 32'hAAAA_0004, 2'b00};
    tbl[8]  = '{1, 1, 2'b11, 32'h1020,
                64'hAAAA_000A_AAAA_0009, 2'b00, 2'd2,
                4'd0, 2'b00, 1, 32'h0, 32'h0, 2'b00};
    tbl[9]  = '{1, 0, 2'b11, 32'h2000,
                64'hBBBB_0002_BBBB_0001, 2'b01, 2'd0,
                4'd2, 2'b11, 1, 32'h2000, 32'h0, 2'b01};
    tbl[10] = '{1, 0, 2'b00, 32'h0, 64'h0, 2'b00, 2'd2,
                4'd0, 2'b00, 1, 32'h0, 32'h0, 2'b00};
    tbl[11] = '{1, 0, 2'b01, 32'h3000,
                64'hDEAD_BEEF_0000_1234, 2'b00, 2'd0,
                4'd1, 2'b01, 1, 32'h3000, 32'h0000_1234, 2'b00};
    tbl[12] = '{1, 0, 2'b11, 32'h3004,
                64'h0000_9ABC_0000_5678, 2'b00, 2'd1,
                4'd2, 2'b11, 1, 32'h3004, 32'h0000_5678, 2'b00};
    tbl[13] = '{0, 0, 2'b11, 32'h4000,
                64'h1111_2222_3333_4444, 2'b00, 2'd0,
                4'd0, 2'b00, 1, 32'h0, 32'h0, 2'b00};

    idle();
    rstn = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].pc, tbl[i].data, 2'b00,
            tbl[i].fault, tbl[i].cons, tbl[i].fl, tbl[i].rn);
      @(posedge clk); #1;
      idle();
      #1;
      chk("t_count", 64'(bus.count_o), 64'(tbl[i].e_cnt));
      chk("t_vld", 64'(bus.out_vld_o), 64'(tbl[i].e_vld));
      chk("t_rdy", 64'(bus.in_rdy_o), 64'(tbl[i].e_rdy));
      if (tbl[i].e_vld[0]) begin
        chk("t_pc0", 64'(bus.out_pc_o[31:0]), 64'(tbl[i].e_pc0));
        chk("t_dat0", 64'(bus.out_data_o[31:0]),
            64'(tbl[i].e_dat0));
        chk("t_flt0", 64'(bus.out_fault_o[1:0]),
            64'(tbl[i].e_flt0));
      end
      if (i == 1)
        chk("t_pc1", 64'(bus.out_pc_o[63:32]), 64'h1004);
      if (i == 9) begin
        chk("t_dat1", 64'(bus.out_data_o[63:32]), 64'h0);
        chk("t_flt1", 64'(bus.out_fault_o[3:2]), 64'h1);
      end
    end

    // Push 2 / retire 1 across the pointer wrap, then drain.
    do_reset();
    ppc = 32'h4000;
    rpc = 32'h4000;
    mcycle(2'b11, ppc, {ppc + 32'h4, ppc}, 2'b01, 2'b00,
           2'd0, 1'b0, 1'b1);
    ppc = ppc + 32'h8;
    for (int c = 0; c < 6; c++) begin
      qs = q.size();
      chk("w_order", 64'(bus.out_pc_o[31:0]), 64'(rpc));
      mcycle(2'b11, ppc, {ppc + 32'h4, ppc}, 2'b10, 2'b00,
             2'd1, 1'b0, 1'b1);
      rpc = rpc + 32'h4;
      if ((D - qs) >= F) ppc = ppc + 32'h8;
    end
    for (int c = 0; c < D && q.size() > 0; c++) begin
      maxc = (q.size() < I) ? q.size() : I;
      chk("w_order", 64'(bus.out_pc_o[31:0]), 64'(rpc));
      mcycle(2'b00, 32'h0, 64'h0, 2'b00, 2'b00,
             2'(maxc), 1'b0, 1'b1);
      rpc = rpc + 32'(4 * maxc);
    end
    chk("w_total", 64'(rpc), 64'(ppc));
    chk("w_empty", 64'(bus.out_vld_o), 64'h0);

`ifdef USC_RV_IBUF_BYPASS_EN
    do_reset();
    drive(2'b11, 32'h5000, 64'h0000_0002_0000_0001, 2'b00,
          2'b00, 2'd1, 1'b0, 1'b1);
    #1;
    chk("b_vld", 64'(bus.out_vld_o), 64'h3);
    chk("b_pc1", 64'(bus.out_pc_o[63:32]), 64'h5004);
    @(posedge clk); #1;
    idle();
    #1;
    chk("b_count", 64'(bus.count_o), 64'h1);
    chk("b_pc0", 64'(bus.out_pc_o[31:0]), 64'h5004);
`endif

    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [1:0] v;
      logic fl;
      logic rn;
      case ($urandom_range(0, 3))
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      maxc = (q.size() < I) ? q.size() : I;
      fl = ($urandom_range(0, 31) == 0);
      rn = ($urandom_range(0, 127) != 0);
      mcycle(v, $urandom() & 32'hFFFF_FFFC,
             {$urandom(), $urandom()}, 2'($urandom()),
             ($urandom_range(0, 7) == 0) ? 2'($urandom()) : 2'b00,
             2'($urandom_range(0, maxc)), fl, rn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
